// File: rtl/dsp_mac_acc.sv
// Sequenced multiply-accumulate engine: takes LEN operand pairs per job, multiplies them,
// adds or subtracts each product into a wide accumulator, then presents the result.
module dsp_mac_acc #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned ACC_WIDTH   = 40,
  parameter int unsigned LEN_WIDTH   = 8,
  parameter int unsigned PIPE_STAGES = 2,
  parameter bit          A_SIGNED    = 1'b0,
  parameter bit          B_SIGNED    = 1'b0,
  parameter bit          SATURATE    = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CE,
  input  logic                 START,
  input  logic [LEN_WIDTH-1:0] LEN,
  input  logic                 SUB,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [ACC_WIDTH-1:0] O,
  output logic                 OVF,
  output logic                 BUSY
);

  localparam int unsigned ProdW      = 2 * WIDTH;
  localparam int unsigned SumW       = ACC_WIDTH + 2;
  localparam int unsigned Last       = PIPE_STAGES - 1;
  localparam bit          SignedMode = A_SIGNED || B_SIGNED;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                 state_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   acpt_cnt_q;
  logic [LEN_WIDTH-1:0]   upd_cnt_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic                   ovf_q;

  logic [ACC_WIDTH-1:0]   pipe_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] pipe_sub_q;
  logic [PIPE_STAGES-1:0] pipe_vld_q;

  logic                   a_sx, b_sx;
  logic [ProdW-1:0]       a_w, b_w, prod;
  logic [ACC_WIDTH-1:0]   prod_ext;
  logic [SumW-1:0]        acc_x, term_x, sum;
  logic [ACC_WIDTH-1:0]   clamp, acc_nxt;
  logic                   ov;
  logic                   accept;
  logic                   upd;

  // Operands are extended to 2*WIDTH first; the low 2*WIDTH bits of the product are then
  // exact for every signedness combination.
  assign a_sx = A_SIGNED & A[WIDTH-1];
  assign b_sx = B_SIGNED & B[WIDTH-1];
  assign a_w  = {{WIDTH{a_sx}}, A};
  assign b_w  = {{WIDTH{b_sx}}, B};
  assign prod = a_w * b_w;

  // Widen the product to accumulator width according to the operand signedness.
  always_comb begin
    if (SignedMode) prod_ext = ACC_WIDTH'($signed(prod));
    else            prod_ext = ACC_WIDTH'(prod);
  end

  // Add/subtract the product leaving the pipeline, detect overflow and pick wrap or clamp.
  always_comb begin
    if (SignedMode) begin
      acc_x  = SumW'($signed(acc_q));
      term_x = SumW'($signed(pipe_q[Last]));
    end else begin
      acc_x  = SumW'(acc_q);
      term_x = SumW'(pipe_q[Last]);
    end
    sum = pipe_sub_q[Last] ? (acc_x - term_x) : (acc_x + term_x);
    if (SignedMode) begin
      // Exact result fits in ACC_WIDTH+1 signed bits; overflow when the top two disagree.
      ov    = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
      clamp = sum[SumW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      // Bit SumW-1 flags a borrow below zero, bit ACC_WIDTH a carry past the maximum.
      ov    = |sum[SumW-1:ACC_WIDTH];
      clamp = sum[SumW-1] ? '0 : '1;
    end
    acc_nxt = (SATURATE && ov) ? clamp : sum[ACC_WIDTH-1:0];
  end

  // Handshakes are gated by CE so a stalled cycle never shows a transfer.
  assign IN_READY  = CE && (state_q == StRun) && (acpt_cnt_q < len_q);
  assign OUT_VALID = CE && (state_q == StDone);
  assign BUSY      = (state_q != StIdle);
  assign O         = acc_q;
  assign OVF       = ovf_q;
  assign accept    = IN_READY && IN_VALID;
  assign upd       = pipe_vld_q[Last];

  // Product/SUB delay line; valid bits mark which stages hold accepted terms.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pipe_vld_q <= '0;
      pipe_sub_q <= '0;
      for (int unsigned i = 0; i < PIPE_STAGES; i++) pipe_q[i] <= '0;
    end else if (CE) begin
      pipe_vld_q[0] <= accept;
      pipe_sub_q[0] <= SUB;
      pipe_q[0]     <= prod_ext;
      for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_sub_q[i] <= pipe_sub_q[i-1];
        pipe_q[i]     <= pipe_q[i-1];
      end
    end
  end

  // Job sequencing, term counters, accumulator and sticky overflow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      len_q      <= '0;
      acpt_cnt_q <= '0;
      upd_cnt_q  <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else if (CE) begin
      if (upd) begin
        acc_q     <= acc_nxt;
        ovf_q     <= ovf_q | ov;
        upd_cnt_q <= upd_cnt_q + LEN_WIDTH'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (START) begin
            len_q      <= LEN;
            acpt_cnt_q <= '0;
            upd_cnt_q  <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            state_q    <= (LEN == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (accept) begin
            acpt_cnt_q <= acpt_cnt_q + LEN_WIDTH'(1);
            if (acpt_cnt_q + LEN_WIDTH'(1) == len_q) state_q <= StDrain;
          end
        end
        StDrain: begin
          // The final term lands in the accumulator on this same edge.
          if (upd && (upd_cnt_q + LEN_WIDTH'(1) == len_q)) state_q <= StDone;
        end
        StDone: begin
          if (OUT_READY) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_mac_acc.sv
// Bench for dsp_mac_acc: three configurations (unsigned/wrap, signed/saturate, signed/wrap)
// driven by shared stimulus; table vectors, directed corner sequences and random jobs
// checked against an integer reference model.
module tb_dsp_mac_acc;

  logic        CLK, RST, CE, START, SUB, IN_VALID, OUT_READY;
  logic [7:0]  LEN;
  logic [15:0] A, B;
  logic        rdy [3];
  logic        ov [3];
  logic        ovf [3];
  logic        busy [3];
  logic [39:0] o0;
  logic [31:0] o1, o2;
  logic [39:0] o_arr [3];

  int cfg_aw [3]  = '{40, 32, 32};
  bit cfg_sgn [3] = '{1'b0, 1'b1, 1'b1};
  bit cfg_sat [3] = '{1'b0, 1'b1, 1'b0};
  int cfg_p [3]   = '{2, 1, 3};

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  dsp_mac_acc u0 (
    .CLK(CLK), .RST(RST), .CE(CE), .START(START), .LEN(LEN), .SUB(SUB),
    .IN_VALID(IN_VALID), .IN_READY(rdy[0]), .A(A), .B(B), .OUT_VALID(ov[0]),
    .OUT_READY(OUT_READY), .O(o0), .OVF(ovf[0]), .BUSY(busy[0])
  );

  dsp_mac_acc #(
    .ACC_WIDTH(32), .PIPE_STAGES(1), .A_SIGNED(1'b1), .B_SIGNED(1'b1), .SATURATE(1'b1)
  ) u1 (
    .CLK(CLK), .RST(RST), .CE(CE), .START(START), .LEN(LEN), .SUB(SUB),
    .IN_VALID(IN_VALID), .IN_READY(rdy[1]), .A(A), .B(B), .OUT_VALID(ov[1]),
    .OUT_READY(OUT_READY), .O(o1), .OVF(ovf[1]), .BUSY(busy[1])
  );

  dsp_mac_acc #(
    .ACC_WIDTH(32), .PIPE_STAGES(3), .A_SIGNED(1'b1), .B_SIGNED(1'b1), .SATURATE(1'b0)
  ) u2 (
    .CLK(CLK), .RST(RST), .CE(CE), .START(START), .LEN(LEN), .SUB(SUB),
    .IN_VALID(IN_VALID), .IN_READY(rdy[2]), .A(A), .B(B), .OUT_VALID(ov[2]),
    .OUT_READY(OUT_READY), .O(o2), .OVF(ovf[2]), .BUSY(busy[2])
  );

  always_comb begin
    o_arr[0] = o0;
    o_arr[1] = {8'h00, o1};
    o_arr[2] = {8'h00, o2};
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: exact integer sum per term, then clamp or wrap into the result range.
  longint m_acc [3];
  bit     m_ovf [3];

  function automatic void ref_clear();
    for (int j = 0; j < 3; j++) begin
      m_acc[j] = 0;
      m_ovf[j] = 1'b0;
    end
  endfunction

  function automatic void ref_term(input logic [15:0] a, input logic [15:0] b, input bit sub);
    for (int j = 0; j < 3; j++) begin
      longint av, bv, s, m, lo, hi;
      av = cfg_sgn[j] ? longint'($signed(a)) : longint'(a);
      bv = cfg_sgn[j] ? longint'($signed(b)) : longint'(b);
      s  = sub ? m_acc[j] - av * bv : m_acc[j] + av * bv;
      m  = longint'(1) << cfg_aw[j];
      lo = cfg_sgn[j] ? -(m / 2) : 0;
      hi = cfg_sgn[j] ? (m / 2) - 1 : m - 1;
      if (s < lo || s > hi) begin
        m_ovf[j] = 1'b1;
        if (cfg_sat[j]) s = (s < lo) ? lo : hi;
        else begin
          s = s % m;
          if (s < 0) s = s + m;
          if (s > hi) s = s - m;
        end
      end
      m_acc[j] = s;
    end
  endfunction

  function automatic logic [39:0] ref_bits(input int j);
    longint m;
    logic [63:0] t;
    m = longint'(1) << cfg_aw[j];
    t = 64'(m_acc[j] & (m - 1));
    return t[39:0];
  endfunction

  // Job driver: terms come from these arrays; results land in res_* per instance.
  logic [15:0] term_a [16];
  logic [15:0] term_b [16];
  bit          term_s [16];
  logic [39:0] res_o [3];
  bit          res_ovf [3];
  int          res_lat [3];
  int          first_k, last_k;

  task automatic run_job(input int len, input bit gaps);
    int  i, budget;
    bit  hit;
    bit  got [3];
    START = 1'b1;
    LEN   = 8'(len);
    step();
    START   = 1'b0;
    last_k  = cyc;
    first_k = -1;
    i = 0;
    budget = 0;
    while (i < len && budget < 400) begin
      IN_VALID = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      A = term_a[i];
      B = term_b[i];
      SUB = term_s[i];
      #1;
      hit = IN_VALID && rdy[0];
      step();
      budget++;
      if (hit) begin
        if (first_k < 0) first_k = cyc;
        last_k = cyc;
        i++;
      end
    end
    IN_VALID = 1'b0;
    chk("terms accepted", 64'(i), 64'(len));
    for (int j = 0; j < 3; j++) begin
      got[j] = 1'b0;
      res_lat[j] = -1;
    end
    for (int t = 0; t < 40; t++) begin
      for (int j = 0; j < 3; j++) begin
        if (!got[j] && ov[j]) begin
          got[j]     = 1'b1;
          res_o[j]   = o_arr[j];
          res_ovf[j] = ovf[j];
          res_lat[j] = cyc - last_k;
        end
      end
      if (got[0] && got[1] && got[2]) break;
      step();
    end
    for (int j = 0; j < 3; j++) chk($sformatf("u%0d OUT_VALID seen", j), 64'(got[j]), 64'd1);
    step();
  endtask

  typedef struct packed {
    logic [3:0]        len;
    logic [3:0][15:0]  a;
    logic [3:0][15:0]  b;
    logic [3:0]        sub;
    logic [2:0][39:0]  e_o;
    logic [2:0]        e_ovf;
  } vec_t;

  vec_t vt [7];
  int   acc_n;
  bit   hit;

  initial begin
    // e_o/e_ovf are {u2, u1, u0}; a/b are {term3, term2, term1, term0}.
    vt[0] = '{len: 4'd3, a: {16'h0, 16'd6, 16'd4, 16'd2}, b: {16'h0, 16'd7, 16'd5, 16'd3},
              sub: 4'b0000, e_o: {40'd68, 40'd68, 40'd68}, e_ovf: 3'b000};
    vt[1] = '{len: 4'd2, a: {16'h0, 16'h0, 16'h0005, 16'hFFFD},
              b: {16'h0, 16'h0, 16'hFFFE, 16'h0004}, sub: 4'b0010,
              e_o: {40'hFFFFFFFE, 40'hFFFFFFFE, 40'hFFFFFEFFFE}, e_ovf: 3'b001};
    vt[2] = '{len: 4'd4, a: {4{16'h8000}}, b: {4{16'h8000}}, sub: 4'b0000,
              e_o: {40'h0, 40'h7FFFFFFF, 40'h0100000000}, e_ovf: 3'b110};
    vt[3] = '{len: 4'd0, a: '0, b: '0, sub: 4'b0000, e_o: '0, e_ovf: 3'b000};
    vt[4] = '{len: 4'd1, a: {16'h0, 16'h0, 16'h0, 16'hFFFF}, b: {16'h0, 16'h0, 16'h0, 16'hFFFF},
              sub: 4'b0001, e_o: {40'hFFFFFFFF, 40'hFFFFFFFF, 40'hFF0001FFFF}, e_ovf: 3'b001};
    vt[5] = '{len: 4'd2, a: {16'h0, 16'h0, 16'h7FFF, 16'h7FFF},
              b: {16'h0, 16'h0, 16'h7FFF, 16'h7FFF}, sub: 4'b0000,
              e_o: {40'h7FFE0002, 40'h7FFE0002, 40'h7FFE0002}, e_ovf: 3'b000};
    vt[6] = '{len: 4'd3, a: {16'h0, 16'h8000, 16'h8000, 16'h8000},
              b: {16'h0, 16'h7FFF, 16'h7FFF, 16'h7FFF}, sub: 4'b0000,
              e_o: {40'h40018000, 40'h80000000, 40'h00BFFE8000}, e_ovf: 3'b110};

    RST = 1'b1; CE = 1'b0; START = 1'b0; LEN = '0; SUB = 1'b0; IN_VALID = 1'b0;
    OUT_READY = 1'b1; A = '0; B = '0;

    // Reset applies even with CE low.
    step();
    step();
    CE = 1'b1;
    #1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("rst u%0d O", j), 64'(o_arr[j]), 64'd0);
      chk($sformatf("rst u%0d OVF", j), 64'(ovf[j]), 64'd0);
      chk($sformatf("rst u%0d OUT_VALID", j), 64'(ov[j]), 64'd0);
      chk($sformatf("rst u%0d IN_READY", j), 64'(rdy[j]), 64'd0);
      chk($sformatf("rst u%0d BUSY", j), 64'(busy[j]), 64'd0);
    end
    RST = 1'b0;
    step();

    // Table vectors, back-to-back terms.
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 4; i++) begin
        term_a[i] = vt[v].a[i];
        term_b[i] = vt[v].b[i];
        term_s[i] = vt[v].sub[i];
      end
      run_job(int'(vt[v].len), 1'b0);
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("vec%0d u%0d O", v, j), 64'(res_o[j]), 64'(vt[v].e_o[j]));
        chk($sformatf("vec%0d u%0d OVF", v, j), 64'(res_ovf[j]), 64'(vt[v].e_ovf[j]));
        chk($sformatf("vec%0d u%0d latency", v, j), 64'(res_lat[j]),
            64'((vt[v].len == 0) ? 0 : cfg_p[j]));
      end
      if (vt[v].len > 1)
        chk($sformatf("vec%0d no bubbles", v), 64'(last_k - first_k), 64'(int'(vt[v].len) - 1));
    end

    // LEN=0 with the consumer stalled: result must hold.
    OUT_READY = 1'b0;
    START = 1'b1;
    LEN = 8'd0;
    step();
    START = 1'b0;
    for (int c = 0; c < 6; c++) begin
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("len0 hold%0d u%0d OUT_VALID", c, j), 64'(ov[j]), 64'd1);
        chk($sformatf("len0 hold%0d u%0d O", c, j), 64'(o_arr[j]), 64'd0);
      end
      step();
    end
    // CE low in DONE: OUT_VALID drops and OUT_READY is ignored.
    CE = 1'b0;
    OUT_READY = 1'b1;
    #1;
    chk("stall OUT_VALID low", 64'(ov[0]), 64'd0);
    step();
    CE = 1'b1;
    OUT_READY = 1'b0;
    #1;
    chk("stall kept DONE", 64'(ov[0]), 64'd1);
    OUT_READY = 1'b1;
    step();
    chk("DONE->IDLE busy", 64'(busy[0]), 64'd0);
    chk("DONE->IDLE OUT_VALID", 64'(ov[2]), 64'd0);

    // CE toggling during a LEN=4 job of (1,1).
    OUT_READY = 1'b0;
    START = 1'b1;
    LEN = 8'd4;
    step();
    START = 1'b0;
    IN_VALID = 1'b1;
    A = 16'd1;
    B = 16'd1;
    SUB = 1'b0;
    acc_n = 0;
    for (int c = 0; c < 40; c++) begin
      CE = c[0];
      #1;
      if (IN_VALID && rdy[0]) acc_n++;
      step();
    end
    CE = 1'b1;
    IN_VALID = 1'b0;
    #1;
    chk("ce toggle accepts", 64'(acc_n), 64'd4);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("ce toggle u%0d OUT_VALID", j), 64'(ov[j]), 64'd1);
      chk($sformatf("ce toggle u%0d O", j), 64'(o_arr[j]), 64'd4);
      chk($sformatf("ce toggle u%0d OVF", j), 64'(ovf[j]), 64'd0);
    end
    OUT_READY = 1'b1;
    step();
    step();

    // Reset while draining abandons the job; a new START right after works.
    term_a[0] = 16'd1; term_b[0] = 16'd1; term_s[0] = 1'b1;
    term_a[1] = 16'd2; term_b[1] = 16'd3; term_s[1] = 1'b0;
    term_a[2] = 16'd4; term_b[2] = 16'd5; term_s[2] = 1'b0;
    START = 1'b1;
    LEN = 8'd3;
    step();
    START = 1'b0;
    acc_n = 0;
    for (int t = 0; t < 20 && acc_n < 3; t++) begin
      IN_VALID = 1'b1;
      A = term_a[acc_n];
      B = term_b[acc_n];
      SUB = term_s[acc_n];
      #1;
      hit = rdy[0];
      step();
      if (hit) acc_n++;
    end
    IN_VALID = 1'b0;
    chk("drain job accepts", 64'(acc_n), 64'd3);
    chk("drain u0 OVF before reset", 64'(ovf[0]), 64'd1);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("drain u%0d busy", j), 64'(busy[j]), 64'd1);
      chk($sformatf("drain u%0d OUT_VALID", j), 64'(ov[j]), 64'd0);
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("drain rst u%0d O", j), 64'(o_arr[j]), 64'd0);
      chk($sformatf("drain rst u%0d OVF", j), 64'(ovf[j]), 64'd0);
      chk($sformatf("drain rst u%0d OUT_VALID", j), 64'(ov[j]), 64'd0);
      chk($sformatf("drain rst u%0d BUSY", j), 64'(busy[j]), 64'd0);
    end
    for (int i = 0; i < 3; i++) begin
      term_a[i] = vt[0].a[i];
      term_b[i] = vt[0].b[i];
      term_s[i] = vt[0].sub[i];
    end
    run_job(3, 1'b0);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("post rst u%0d O", j), 64'(res_o[j]), 64'd68);
      chk($sformatf("post rst u%0d OVF", j), 64'(res_ovf[j]), 64'd0);
    end

    // Random jobs with input gaps against the reference model.
    for (int r = 0; r < 24; r++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        for (int k = 0; k < 2; k++) begin
          logic [15:0] val;
          case ($urandom_range(0, 5))
            0: val = 16'h8000;
            1: val = 16'h7FFF;
            2: val = 16'hFFFF;
            default: val = 16'($urandom);
          endcase
          if (k == 0) term_a[i] = val;
          else        term_b[i] = val;
        end
        term_s[i] = 1'($urandom_range(0, 1));
      end
      run_job(len, 1'b1);
      ref_clear();
      for (int i = 0; i < len; i++) ref_term(term_a[i], term_b[i], term_s[i]);
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("rand%0d u%0d O", r, j), 64'(res_o[j]), 64'(ref_bits(j)));
        chk($sformatf("rand%0d u%0d OVF", r, j), 64'(res_ovf[j]), 64'(m_ovf[j]));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
